// File: rtl/ulpi_reg_engine.sv
// ulpi_reg_engine: ULPI PHY register-access engine in the ulpi_clk domain.
// It takes one request at a time from the CSR bridge and sends the matching
// ULPI command sequence on the TX byte stream. For reads it captures the register
// byte from the RX stream. It then returns a response with an error code.
// A PHY RX byte that arrives while a sequence is in progress aborts that attempt.
// Aborted attempts are retried, up to a limit. A transaction that makes no
// progress for too long ends with a timeout response.
//
// Ports:
//   i_ulpi_clk, i_ulpi_rst          clock, synchronous active-high reset
//   i_req_valid/o_req_ready         request handshake (write, addr, wdata)
//   o_rsp_valid/i_rsp_ready         response handshake (rdata, err: 00 ok,
//                                   01 retries exhausted, 10 timeout)
//   o_tx_t*/i_tx_tready             TX byte stream towards ulpi_axis
//   i_rx_t*                         RX byte stream from ulpi_axis, always accepted;
//                                   tuser[0] non-packet byte, tuser[1] rx_active
//   o_stat_aborts                   saturating count of aborted bus attempts
//   o_busy                          engine not idle
module ulpi_reg_engine #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned MAX_RETRY  = 3,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                  i_ulpi_clk,
  input  logic                  i_ulpi_rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_write,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [7:0]            i_req_wdata,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [7:0]            o_rsp_rdata,
  output logic [1:0]            o_rsp_err,
  output logic                  o_tx_tvalid,
  input  logic                  i_tx_tready,
  output logic [7:0]            o_tx_tdata,
  output logic                  o_tx_tlast,
  input  logic                  i_rx_tvalid,
  input  logic [7:0]            i_rx_tdata,
  input  logic [1:0]            i_rx_tuser,
  output logic [15:0]           o_stat_aborts,
  output logic                  o_busy
);

  localparam int unsigned RW = $clog2(MAX_RETRY + 2);
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST     = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [5:0]    EXT_CMD_ADDR = 6'h2F;
  localparam logic [1:0]    ERR_OK       = 2'b00;
  localparam logic [1:0]    ERR_RETRY    = 2'b01;
  localparam logic [1:0]    ERR_TMO      = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_EXT, S_DATA, S_READ, S_ABORT, S_RESP
  } state_t;

  state_t          r_state;
  logic            r_write;
  logic [7:0]      r_addr;
  logic [7:0]      r_wdata;
  logic [RW-1:0]   r_retry;
  logic [TW-1:0]   r_tmo;
  logic            r_tx_tvalid;
  logic [7:0]      r_tx_tdata;
  logic            r_tx_tlast;
  logic            r_rsp_valid;
  logic [7:0]      r_rsp_rdata;
  logic [1:0]      r_rsp_err;
  logic [15:0]     r_aborts;
  logic            r_busy;

  logic [7:0]      w_req_addr;
  logic            w_ext;
  logic [7:0]      w_cmd;
  logic            w_tmo_hit;
  logic [15:0]     w_aborts_inc;

  // Addresses above the immediate range, and 0x2F itself (the escape code),
  // go through the extended-register escape.
  function automatic logic f_ext(input logic [7:0] addr);
    return (ADDR_WIDTH == 8) && ((addr[7:6] != 2'b00) || (addr[5:0] == EXT_CMD_ADDR));
  endfunction

  function automatic logic [7:0] f_cmd(input logic write, input logic [7:0] addr);
    return {1'b1, ~write, f_ext(addr) ? EXT_CMD_ADDR : addr[5:0]};
  endfunction

  assign w_req_addr   = 8'(i_req_addr);
  assign w_ext        = f_ext(r_addr);
  assign w_cmd        = f_cmd(r_write, r_addr);
  assign w_tmo_hit    = (TIMEOUT != 0) && (r_tmo == TMO_LAST);
  assign w_aborts_inc = (r_aborts == 16'hFFFF) ? r_aborts : r_aborts + 16'd1;

  // Transaction FSM. Outputs are updated on the same edge as the state change.
  always_ff @(posedge i_ulpi_clk) begin
    if (i_ulpi_rst) begin
      r_state     <= S_IDLE;
      r_write     <= 1'b0;
      r_addr      <= 8'h00;
      r_wdata     <= 8'h00;
      r_retry     <= '0;
      r_tmo       <= '0;
      r_tx_tvalid <= 1'b0;
      r_tx_tdata  <= 8'h00;
      r_tx_tlast  <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 8'h00;
      r_rsp_err   <= ERR_OK;
      r_aborts    <= 16'h0000;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_req_valid) begin
            r_write     <= i_req_write;
            r_addr      <= w_req_addr;
            r_wdata     <= i_req_wdata;
            r_retry     <= '0;
            r_tmo       <= '0;
            r_tx_tvalid <= 1'b1;
            r_tx_tdata  <= f_cmd(i_req_write, w_req_addr);
            r_tx_tlast  <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= S_CMD;
          end
        end

        S_CMD, S_EXT, S_DATA: begin
          // A PHY RX byte beats a TX handshake in the same cycle.
          if (i_rx_tvalid) begin
            r_tx_tvalid <= 1'b0;
            r_tx_tlast  <= 1'b0;
            r_aborts    <= w_aborts_inc;
            r_retry     <= r_retry + RW'(1);
            r_tmo       <= '0;
            r_state     <= S_ABORT;
          end else if (i_tx_tready) begin
            r_tmo <= '0;
            if (r_state == S_CMD && w_ext) begin
              r_tx_tdata <= r_addr;
              r_state    <= S_EXT;
            end else if (r_state == S_DATA) begin
              r_tx_tvalid <= 1'b0;
              r_tx_tlast  <= 1'b0;
              r_rsp_valid <= 1'b1;
              r_rsp_rdata <= 8'h00;
              r_rsp_err   <= ERR_OK;
              r_state     <= S_RESP;
            end else if (r_write) begin
              r_tx_tdata <= r_wdata;
              r_tx_tlast <= 1'b1;
              r_state    <= S_DATA;
            end else begin
              r_tx_tvalid <= 1'b0;
              r_state     <= S_READ;
            end
          end else if (w_tmo_hit) begin
            r_tx_tvalid <= 1'b0;
            r_tx_tlast  <= 1'b0;
            r_tmo       <= '0;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= 8'h00;
            r_rsp_err   <= ERR_TMO;
            r_state     <= S_RESP;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end

        S_READ: begin
          // Only a non-packet byte outside rx_active is register data.
          if (i_rx_tvalid) begin
            r_tmo <= '0;
            if (i_rx_tuser == 2'b01) begin
              r_rsp_valid <= 1'b1;
              r_rsp_rdata <= i_rx_tdata;
              r_rsp_err   <= ERR_OK;
              r_state     <= S_RESP;
            end else begin
              r_aborts <= w_aborts_inc;
              r_retry  <= r_retry + RW'(1);
              r_state  <= S_ABORT;
            end
          end else if (w_tmo_hit) begin
            r_tmo       <= '0;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= 8'h00;
            r_rsp_err   <= ERR_TMO;
            r_state     <= S_RESP;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end

        S_ABORT: begin
          // Let the PHY finish its RX burst, then retry from the command byte.
          if (!i_rx_tvalid) begin
            r_tmo <= '0;
            if (r_retry > RW'(MAX_RETRY)) begin
              r_rsp_valid <= 1'b1;
              r_rsp_rdata <= 8'h00;
              r_rsp_err   <= ERR_RETRY;
              r_state     <= S_RESP;
            end else begin
              r_tx_tvalid <= 1'b1;
              r_tx_tdata  <= w_cmd;
              r_tx_tlast  <= 1'b0;
              r_state     <= S_CMD;
            end
          end
        end

        S_RESP: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_req_ready   = (r_state == S_IDLE) & ~i_ulpi_rst;
  assign o_rsp_valid   = r_rsp_valid;
  assign o_rsp_rdata   = r_rsp_rdata;
  assign o_rsp_err     = r_rsp_err;
  assign o_tx_tvalid   = r_tx_tvalid;
  assign o_tx_tdata    = r_tx_tdata;
  assign o_tx_tlast    = r_tx_tlast;
  assign o_stat_aborts = r_aborts;
  assign o_busy        = r_busy;

endmodule

// File: tb/tb_ulpi_reg_engine.sv
// tb_ulpi_reg_engine: directed bench for ulpi_reg_engine.
// The main instance uses the default parameters. A behavioural transaction model
// checks it on every cycle, and hand-computed literals check each scenario.
// A second instance uses ADDR_WIDTH=6 and TIMEOUT=0 and is checked only
// against literals.
module tb_ulpi_reg_engine;

  localparam int TMO = 64;
  localparam int MR  = 3;
  localparam int P_IDLE = 0, P_SEND = 1, P_READ = 2, P_ABORT = 3, P_RESP = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance
  logic        rst, req_valid, req_write, rsp_ready, tx_tready, rx_tvalid;
  logic [7:0]  req_addr, req_wdata, rx_tdata;
  logic [1:0]  rx_tuser;
  logic        o_req_ready, o_rsp_valid, o_tx_tvalid, o_tx_tlast, o_busy;
  logic [7:0]  o_rsp_rdata, o_tx_tdata;
  logic [1:0]  o_rsp_err;
  logic [15:0] o_stat_aborts;

  // ADDR_WIDTH=6, TIMEOUT=0 instance
  logic        b_rst, b_req_valid, b_req_write, b_rsp_ready, b_tx_tready, b_rx_tvalid;
  logic [5:0]  b_req_addr;
  logic [7:0]  b_req_wdata, b_rx_tdata;
  logic [1:0]  b_rx_tuser;
  logic        b_req_ready, b_rsp_valid, b_tx_tvalid, b_tx_tlast, b_busy;
  logic [7:0]  b_rsp_rdata, b_tx_tdata;
  logic [1:0]  b_rsp_err;
  logic [15:0] b_stat_aborts;

  ulpi_reg_engine #(.ADDR_WIDTH(8), .MAX_RETRY(MR), .TIMEOUT(TMO)) dut (
    .i_ulpi_clk(clk), .i_ulpi_rst(rst),
    .i_req_valid(req_valid), .o_req_ready(o_req_ready), .i_req_write(req_write),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_rdata(o_rsp_rdata),
    .o_rsp_err(o_rsp_err),
    .o_tx_tvalid(o_tx_tvalid), .i_tx_tready(tx_tready), .o_tx_tdata(o_tx_tdata),
    .o_tx_tlast(o_tx_tlast),
    .i_rx_tvalid(rx_tvalid), .i_rx_tdata(rx_tdata), .i_rx_tuser(rx_tuser),
    .o_stat_aborts(o_stat_aborts), .o_busy(o_busy)
  );

  ulpi_reg_engine #(.ADDR_WIDTH(6), .MAX_RETRY(MR), .TIMEOUT(0)) dut_b (
    .i_ulpi_clk(clk), .i_ulpi_rst(b_rst),
    .i_req_valid(b_req_valid), .o_req_ready(b_req_ready), .i_req_write(b_req_write),
    .i_req_addr(b_req_addr), .i_req_wdata(b_req_wdata),
    .o_rsp_valid(b_rsp_valid), .i_rsp_ready(b_rsp_ready), .o_rsp_rdata(b_rsp_rdata),
    .o_rsp_err(b_rsp_err),
    .o_tx_tvalid(b_tx_tvalid), .i_tx_tready(b_tx_tready), .o_tx_tdata(b_tx_tdata),
    .o_tx_tlast(b_tx_tlast),
    .i_rx_tvalid(b_rx_tvalid), .i_rx_tdata(b_rx_tdata), .i_rx_tuser(b_rx_tuser),
    .o_stat_aborts(b_stat_aborts), .o_busy(b_busy)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Bytes handed over on the main TX stream: {tlast, tdata}
  logic [8:0] txlog[$];

  task automatic chk_log(input string nm, input int n, input logic [8:0] e0,
                         input logic [8:0] e1, input logic [8:0] e2);
    logic [8:0] e[3];
    e[0] = e0; e[1] = e1; e[2] = e2;
    chk({nm, "_len"}, 32'(txlog.size()), 32'(n));
    for (int i = 0; i < n && i < int'(txlog.size()); i++)
      chk($sformatf("%s_b%0d", nm, i), 32'(txlog[i]), 32'(e[i]));
  endtask

  // Transaction model: a request becomes a list of bytes, sent in order; an abort
  // restarts the list. The model tracks the phase and the response.
  int         m_ph = P_IDLE;
  logic [7:0] m_seq[3];
  int         m_len = 0, m_pos = 0, m_wait = 0, m_tries = 0;
  logic       m_wr = 1'b0;
  logic [15:0] m_ab = 16'h0;
  logic [7:0] m_rd = 8'h00;
  logic [1:0] m_er = 2'b00;
  bit         mon_en = 1'b0;

  function automatic logic is_ext(input logic [7:0] a);
    return (a[7:6] != 2'b00) || (a[5:0] == 6'h2F);
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("req_ready", 32'(o_req_ready), 32'((m_ph == P_IDLE) && !rst));
        chk("busy", 32'(o_busy), 32'(m_ph != P_IDLE));
        chk("tx_tvalid", 32'(o_tx_tvalid), 32'(m_ph == P_SEND));
        if (m_ph == P_SEND) begin
          chk("tx_tdata", 32'(o_tx_tdata), 32'(m_seq[m_pos]));
          chk("tx_tlast", 32'(o_tx_tlast), 32'(m_wr && (m_pos == m_len - 1)));
        end
        chk("rsp_valid", 32'(o_rsp_valid), 32'(m_ph == P_RESP));
        if (m_ph == P_RESP) begin
          chk("rsp_rdata", 32'(o_rsp_rdata), 32'(m_rd));
          chk("rsp_err", 32'(o_rsp_err), 32'(m_er));
        end
        chk("stat_aborts", 32'(o_stat_aborts), 32'(m_ab));
        if (o_tx_tvalid && tx_tready && !rx_tvalid && !rst)
          txlog.push_back({o_tx_tlast, o_tx_tdata});

        // advance to the next edge
        if (rst) begin
          m_ph = P_IDLE;
          m_ab = 16'h0;
        end else begin
          case (m_ph)
            P_IDLE: if (req_valid) begin
              m_wr = req_write;
              m_seq[0] = {1'b1, ~req_write, is_ext(req_addr) ? 6'h2F : req_addr[5:0]};
              m_len = 1;
              if (is_ext(req_addr)) begin m_seq[m_len] = req_addr; m_len++; end
              if (req_write) begin m_seq[m_len] = req_wdata; m_len++; end
              m_pos = 0; m_wait = 0; m_tries = 0;
              m_ph = P_SEND;
            end
            P_SEND: begin
              if (rx_tvalid) begin
                if (m_ab != 16'hFFFF) m_ab = m_ab + 16'd1;
                m_tries++;
                m_ph = P_ABORT;
              end else if (tx_tready) begin
                m_pos++;
                m_wait = 0;
                if (m_pos == m_len) begin
                  if (m_wr) begin m_ph = P_RESP; m_rd = 8'h00; m_er = 2'b00; end
                  else m_ph = P_READ;
                end
              end else if (TMO != 0 && m_wait == TMO - 1) begin
                m_ph = P_RESP; m_rd = 8'h00; m_er = 2'b10;
              end else m_wait++;
            end
            P_READ: begin
              if (rx_tvalid) begin
                m_wait = 0;
                if (rx_tuser == 2'b01) begin
                  m_ph = P_RESP; m_rd = rx_tdata; m_er = 2'b00;
                end else begin
                  if (m_ab != 16'hFFFF) m_ab = m_ab + 16'd1;
                  m_tries++;
                  m_ph = P_ABORT;
                end
              end else if (TMO != 0 && m_wait == TMO - 1) begin
                m_ph = P_RESP; m_rd = 8'h00; m_er = 2'b10;
              end else m_wait++;
            end
            P_ABORT: if (!rx_tvalid) begin
              if (m_tries > MR) begin
                m_ph = P_RESP; m_rd = 8'h00; m_er = 2'b01;
              end else begin
                m_ph = P_SEND; m_pos = 0; m_wait = 0;
              end
            end
            P_RESP: if (rsp_ready) m_ph = P_IDLE;
            default: m_ph = P_IDLE;
          endcase
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns in the cycle after the accept edge.
  task automatic send_req(input logic w, input logic [7:0] a, input logic [7:0] d);
    int n;
    n = 0;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    while (!o_req_ready && n < 200) begin tick(); n++; end
    chk("req_accept", 32'(o_req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!o_rsp_valid && n < 300) begin tick(); n++; end
    chk("rsp_seen", 32'(o_rsp_valid), 32'd1);
  endtask

  initial begin
    int n, nv;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 8'h00; req_wdata = 8'h00;
    rsp_ready = 1'b1; tx_tready = 1'b1; rx_tvalid = 1'b0; rx_tdata = 8'h00; rx_tuser = 2'b00;
    b_rst = 1'b1; b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = 6'h00;
    b_req_wdata = 8'h00; b_rsp_ready = 1'b1; b_tx_tready = 1'b0; b_rx_tvalid = 1'b0;
    b_rx_tdata = 8'h00; b_rx_tuser = 2'b00;
    tick(); tick();
    mon_en = 1'b1;

    // reset state
    chk("rst_tx_tvalid", 32'(o_tx_tvalid), 32'd0);
    chk("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
    chk("rst_rsp_rdata", 32'(o_rsp_rdata), 32'd0);
    chk("rst_rsp_err", 32'(o_rsp_err), 32'd0);
    chk("rst_aborts", 32'(o_stat_aborts), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_req_ready", 32'(o_req_ready), 32'd0);
    rst = 1'b0; b_rst = 1'b0;
    tick();
    chk("idle_req_ready", 32'(o_req_ready), 32'd1);

    // T1: immediate write, no stalls
    txlog.delete();
    send_req(1'b1, 8'h0A, 8'h55);
    wait_rsp(n);
    chk("t1_latency", 32'(n), 32'd2);
    chk("t1_err", 32'(o_rsp_err), 32'd0);
    chk("t1_rdata", 32'(o_rsp_rdata), 32'd0);
    tick();
    chk_log("t1_tx", 2, 9'h08A, 9'h155, 9'h000);

    // T2: extended read, response held while rsp_ready is low
    txlog.delete();
    rsp_ready = 1'b0;
    send_req(1'b0, 8'h95, 8'h00);
    tick(); tick();
    rx_tvalid = 1'b1; rx_tdata = 8'h3C; rx_tuser = 2'b01;
    tick();
    rx_tvalid = 1'b0; rx_tuser = 2'b00;
    wait_rsp(n);
    tick(); tick(); tick();
    chk("t2_hold_valid", 32'(o_rsp_valid), 32'd1);
    chk("t2_rdata", 32'(o_rsp_rdata), 32'h3C);
    chk("t2_err", 32'(o_rsp_err), 32'd0);
    rsp_ready = 1'b1;
    tick();
    chk_log("t2_tx", 2, 9'h0EF, 9'h095, 9'h000);

    // T3: RX burst during the data byte forces one restart
    txlog.delete();
    send_req(1'b1, 8'h04, 8'hA7);
    tick();
    rx_tvalid = 1'b1; rx_tuser = 2'b00;
    tick(); tick(); tick();
    rx_tvalid = 1'b0;
    wait_rsp(n);
    chk("t3_err", 32'(o_rsp_err), 32'd0);
    chk("t3_aborts", 32'(o_stat_aborts), 32'd1);
    tick();
    chk_log("t3_tx", 3, 9'h084, 9'h084, 9'h1A7);

    // T4: every attempt aborted -> retries exhausted
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t4_aborts_clr", 32'(o_stat_aborts), 32'd0);
    txlog.delete();
    tx_tready = 1'b0;
    send_req(1'b0, 8'h10, 8'h00);
    for (int i = 0; i < 4; i++) begin
      nv = 0;
      while (!o_tx_tvalid && nv < 50) begin tick(); nv++; end
      rx_tvalid = 1'b1; rx_tuser = 2'b10;
      tick();
      rx_tvalid = 1'b0; rx_tuser = 2'b00;
      tick();
    end
    wait_rsp(n);
    chk("t4_err", 32'(o_rsp_err), 32'd1);
    chk("t4_rdata", 32'(o_rsp_rdata), 32'd0);
    chk("t4_aborts", 32'(o_stat_aborts), 32'd4);
    tick();
    chk("t4_req_ready", 32'(o_req_ready), 32'd1);
    chk_log("t4_tx", 0, 9'h000, 9'h000, 9'h000);

    // T5: tx_tready stuck low -> timeout after 64 cycles in the command state
    txlog.delete();
    send_req(1'b1, 8'h01, 8'h11);
    n = 0; nv = 0;
    while (!o_rsp_valid && n < 300) begin
      if (o_tx_tvalid) nv++;
      tick(); n++;
    end
    chk("t5_rsp_seen", 32'(o_rsp_valid), 32'd1);
    chk("t5_cmd_cycles", 32'(nv), 32'd64);
    chk("t5_err", 32'(o_rsp_err), 32'd2);
    chk("t5_tx_tvalid", 32'(o_tx_tvalid), 32'd0);
    tick();
    chk("t5_busy", 32'(o_busy), 32'd0);

    // T5b: progress in the last counted cycle beats the timeout
    txlog.delete();
    send_req(1'b1, 8'h01, 8'h22);
    repeat (63) tick();
    tx_tready = 1'b1;
    wait_rsp(n);
    chk("t5b_err", 32'(o_rsp_err), 32'd0);
    tick();
    chk_log("t5b_tx", 2, 9'h081, 9'h122, 9'h000);

    // T6: reset while waiting for read data, then a read with one rejected RX byte
    send_req(1'b0, 8'h21, 8'h00);
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    nv = 0;
    for (int i = 0; i < 6; i++) begin
      if (o_rsp_valid) nv++;
      tick();
    end
    chk("t6_no_rsp", 32'(nv), 32'd0);
    chk("t6_busy", 32'(o_busy), 32'd0);
    txlog.delete();
    send_req(1'b0, 8'h21, 8'h00);
    tick();
    rx_tvalid = 1'b1; rx_tdata = 8'hFF; rx_tuser = 2'b11;
    tick();
    rx_tvalid = 1'b0; rx_tuser = 2'b00;
    tick(); tick();
    rx_tvalid = 1'b1; rx_tdata = 8'h5A; rx_tuser = 2'b01;
    tick();
    rx_tvalid = 1'b0; rx_tuser = 2'b00;
    wait_rsp(n);
    chk("t6_rdata", 32'(o_rsp_rdata), 32'h5A);
    chk("t6_err", 32'(o_rsp_err), 32'd0);
    chk("t6_aborts", 32'(o_stat_aborts), 32'd1);
    tick();
    chk_log("t6_tx", 2, 9'h0E1, 9'h0E1, 9'h000);

    // 6-bit addresses: 0x2F is an immediate read; TIMEOUT=0 never gives up
    chk("b_req_ready", 32'(b_req_ready), 32'd1);
    b_req_valid = 1'b1; b_req_write = 1'b0; b_req_addr = 6'h2F;
    tick();
    b_req_valid = 1'b0;
    repeat (100) tick();
    chk("b_tx_tvalid_held", 32'(b_tx_tvalid), 32'd1);
    chk("b_tx_tdata", 32'(b_tx_tdata), 32'hEF);
    chk("b_tx_tlast", 32'(b_tx_tlast), 32'd0);
    chk("b_no_rsp", 32'(b_rsp_valid), 32'd0);
    chk("b_busy", 32'(b_busy), 32'd1);
    b_tx_tready = 1'b1;
    tick();
    b_tx_tready = 1'b0;
    chk("b_no_ext_byte", 32'(b_tx_tvalid), 32'd0);
    b_rx_tvalid = 1'b1; b_rx_tdata = 8'h99; b_rx_tuser = 2'b01;
    tick();
    b_rx_tvalid = 1'b0; b_rx_tuser = 2'b00;
    chk("b_rsp_valid", 32'(b_rsp_valid), 32'd1);
    chk("b_rdata", 32'(b_rsp_rdata), 32'h99);
    chk("b_err", 32'(b_rsp_err), 32'd0);
    chk("b_aborts", 32'(b_stat_aborts), 32'd0);
    tick();
    chk("b_idle", 32'(b_busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
